// File: rtl/srambank_pkg.sv
// Shared types and width helpers for the banked SRAM pipeline.
// bank_state_t is only used when SRAMBANK_SLEEP_EN is defined.
package srambank_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } bank_state_t;

  function automatic int unsigned addr_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int unsigned sel_w(input int unsigned nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

  function automatic int unsigned sub_depth(input int unsigned words, input int unsigned nbank);
    return words / nbank;
  endfunction

endpackage

// File: rtl/srambank_subbank.sv
// One sub-bank: byte-masked write array plus registered read port.
// With SRAMBANK_SLEEP_EN defined, an idle counter puts the sub-bank to sleep.
module srambank_subbank
  import srambank_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned IDLE_CYC = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sel,
  input  logic                      rd,
  input  logic                      wr,
  input  logic [addr_w(DEPTH)-1:0]  addr,
  input  logic [WIDTH-1:0]          wd,
  input  logic [WIDTH/8-1:0]        wmask,
  output logic                      rdy,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             acc;

  assign acc = sel & rdy;

  always_ff @(posedge clk) begin
    if (acc && wr) begin
      for (int unsigned i = 0; i < WIDTH/8; i++) begin
        if (wmask[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Read-with-write is dropped, so rdata only loads on a pure read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (acc && rd && !wr) begin
      rdata <= mem[addr];
    end
  end

`ifdef SRAMBANK_SLEEP_EN
  localparam int unsigned CW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

  bank_state_t   state;
  logic [CW-1:0] idle;

  assign rdy = (state == ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACTIVE;
      idle  <= '0;
    end else begin
      case (state)
        ACTIVE: begin
          if (sel) begin
            idle <= '0;
          end else if (idle == CW'(IDLE_CYC - 1)) begin
            state <= SLEEP;
            idle  <= '0;
          end else begin
            idle <= idle + 1'b1;
          end
        end
        SLEEP: if (sel) state <= WAKE;
        WAKE: begin
          state <= ACTIVE;
          idle  <= '0;
        end
        default: begin
          state <= ACTIVE;
          idle  <= '0;
        end
      endcase
    end
  end
`else
  assign rdy = 1'b1;
`endif

endmodule

// File: rtl/srambank_pipe.sv
// Banked SRAM with byte-masked writes, RD_LAT read pipeline and collision flag.
// Define SRAMBANK_SLEEP_EN to enable per-sub-bank idle sleep with ready handshake.
module srambank_pipe
  import srambank_pkg::*;
#(
  parameter int unsigned WORDS    = 1024,
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NBANK    = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned IDLE_CYC = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [addr_w(WORDS)-1:0]  ADDRESS,
  input  logic [WIDTH-1:0]          wd,
  input  logic [WIDTH/8-1:0]        wmask,
  input  logic                      banksel,
  input  logic                      read,
  input  logic                      write,
  output logic                      ready,
  output logic [WIDTH-1:0]          dataout,
  output logic                      dvalid,
  output logic                      collide
);

  localparam int unsigned AW     = addr_w(WORDS);
  localparam int unsigned SW     = sel_w(NBANK);
  localparam int unsigned DEPTH  = sub_depth(WORDS, NBANK);
  localparam int unsigned SUB_AW = addr_w(DEPTH);

  logic              req, acc, rd_acc;
  logic [SW-1:0]     bidx, bank_q;
  logic [NBANK-1:0]  rdy, sel;
  logic [WIDTH-1:0]  rdata [NBANK];
  logic [WIDTH-1:0]  stage0;
  logic [RD_LAT-1:0] vld;

  if (NBANK > 1) begin : g_bidx
    assign bidx = ADDRESS[AW-1 -: SW];
  end else begin : g_bidx1
    assign bidx = '0;
  end

  assign req    = banksel & (read | write);
  assign ready  = ~req | rdy[bidx];
  assign acc    = req & ready;
  assign rd_acc = acc & read & ~write;

  always_comb begin
    sel = '0;
    sel[bidx] = req;
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    srambank_subbank #(
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH),
      .IDLE_CYC (IDLE_CYC)
    ) u_sub (
      .clk   (clk),
      .reset (reset),
      .sel   (sel[b]),
      .rd    (read),
      .wr    (write),
      .addr  (ADDRESS[SUB_AW-1:0]),
      .wd    (wd),
      .wmask (wmask),
      .rdy   (rdy[b]),
      .rdata (rdata[b])
    );
  end

  // The sub-bank read register is pipeline stage 1; bank_q steers the mux.
  assign stage0 = rdata[bank_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q  <= '0;
      vld     <= '0;
      collide <= 1'b0;
    end else begin
      if (rd_acc) bank_q <= bidx;
      vld[0] <= rd_acc;
      for (int unsigned k = 1; k < RD_LAT; k++) vld[k] <= vld[k-1];
      collide <= acc & read & write;
    end
  end

  assign dvalid = vld[RD_LAT-1];

  if (RD_LAT == 1) begin : g_lat1
    assign dataout = stage0;
  end else begin : g_latn
    logic [WIDTH-1:0] pipe_q [1:RD_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned k = 1; k < RD_LAT; k++) pipe_q[k] <= '0;
      end else begin
        if (vld[0]) pipe_q[1] <= stage0;
        for (int unsigned k = 2; k < RD_LAT; k++) begin
          if (vld[k-1]) pipe_q[k] <= pipe_q[k-1];
        end
      end
    end

    assign dataout = pipe_q[RD_LAT-1];
  end

endmodule

// File: tb/tb_srambank_pipe.sv
// Directed bench for srambank_pipe: two instances (RD_LAT=2 and RD_LAT=3)
// share one stimulus stream; sleep expectations follow SRAMBANK_SLEEP_EN.
module tb_srambank_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  ADDRESS = '0;
  logic [63:0] wd = '0;
  logic [7:0]  wmask = '0;
  logic        banksel = 1'b0, read = 1'b0, write = 1'b0;
  logic        ready_a, dvalid_a, collide_a, ready_b, dvalid_b, collide_b;
  logic [63:0] dataout_a, dataout_b;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  srambank_pipe #(.WORDS(1024), .WIDTH(64), .NBANK(4), .RD_LAT(2), .IDLE_CYC(4)) dut_a (
    .clk(clk), .reset(reset), .ADDRESS(ADDRESS), .wd(wd), .wmask(wmask),
    .banksel(banksel), .read(read), .write(write), .ready(ready_a),
    .dataout(dataout_a), .dvalid(dvalid_a), .collide(collide_a)
  );

  srambank_pipe #(.WORDS(1024), .WIDTH(64), .NBANK(4), .RD_LAT(3), .IDLE_CYC(4)) dut_b (
    .clk(clk), .reset(reset), .ADDRESS(ADDRESS), .wd(wd), .wmask(wmask),
    .banksel(banksel), .read(read), .write(write), .ready(ready_b),
    .dataout(dataout_b), .dvalid(dvalid_b), .collide(collide_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold the request until ready, then drop it one edge after acceptance.
  task automatic access(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [63:0] d, input logic [7:0] m, output int waits);
    banksel = 1'b1; read = rd; write = wr; ADDRESS = a; wd = d; wmask = m;
    waits = 0;
    #1;
    while (!ready_a && waits < 10) begin
      waits++;
      @(posedge clk); #1;
    end
    check("ready_bound", 64'(waits < 10), 64'd1);
    @(posedge clk); #1;
    banksel = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [9:0] a, input logic [63:0] exp,
                            output int waits);
    access(1'b1, 1'b0, a, '0, '0, waits);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check({tag, "_dvalid_a"}, 64'(dvalid_a), 64'(c == 2));
      check({tag, "_dvalid_b"}, 64'(dvalid_b), 64'(c == 3));
      if (c >= 2) check({tag, "_data_a"}, dataout_a, exp);
      if (c >= 3) check({tag, "_data_b"}, dataout_b, exp);
    end
  endtask

  initial begin
    int w;
    int exp_wake;
    logic [63:0] v [4];

`ifdef SRAMBANK_SLEEP_EN
    exp_wake = 2;
`else
    exp_wake = 0;
`endif

    #2 reset = 1'b1;
    #1;
    check("rst_dataout_a", dataout_a, 64'd0);
    check("rst_dataout_b", dataout_b, 64'd0);
    check("rst_dvalid", 64'({dvalid_a, dvalid_b}), 64'd0);
    check("rst_collide", 64'({collide_a, collide_b}), 64'd0);
    check("rst_ready", 64'({ready_a, ready_b}), 64'd3);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic write then read.
    access(1'b0, 1'b1, 10'd5, 64'hDEADBEEF_01234567, 8'hFF, w);
    read_check("basic", 10'd5, 64'hDEADBEEF_01234567, w);

    // Byte masking, then an all-zero mask as a no-op.
    access(1'b0, 1'b1, 10'd9, 64'h11111111_11111111, 8'hFF, w);
    access(1'b0, 1'b1, 10'd9, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, w);
    read_check("bmask", 10'd9, 64'h11111111_FFFFFFFF, w);
    access(1'b0, 1'b1, 10'd9, 64'h0, 8'h00, w);
    read_check("mask0", 10'd9, 64'h11111111_FFFFFFFF, w);

    // Write behind an in-flight read must not alter the returned data.
    access(1'b1, 1'b0, 10'd9, '0, '0, w);
    access(1'b0, 1'b1, 10'd9, 64'h01234567_89ABCDEF, 8'hFF, w);
    @(negedge clk);
    check("inflight_dvalid_a", 64'(dvalid_a), 64'd1);
    check("inflight_data_a", dataout_a, 64'h11111111_FFFFFFFF);
    @(negedge clk);
    check("inflight_dvalid_b", 64'(dvalid_b), 64'd1);
    check("inflight_data_b", dataout_b, 64'h11111111_FFFFFFFF);
    read_check("after_inflight", 10'd9, 64'h01234567_89ABCDEF, w);

    // Collision: write wins, read dropped, collide pulses once.
    access(1'b1, 1'b1, 10'd7, 64'hA5A5A5A5_A5A5A5A5, 8'hFF, w);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("coll_collide_a", 64'(collide_a), 64'(c == 1));
      check("coll_collide_b", 64'(collide_b), 64'(c == 1));
      check("coll_no_dvalid", 64'({dvalid_a, dvalid_b}), 64'd0);
    end
    read_check("coll_read", 10'd7, 64'hA5A5A5A5_A5A5A5A5, w);

    // Back-to-back reads of addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      v[i] = 64'hC0DE0000_00000000 | 64'(i * 17 + 1);
      access(1'b0, 1'b1, 10'(i), v[i], 8'hFF, w);
    end
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        banksel = 1'b1; read = 1'b1; write = 1'b0; ADDRESS = 10'(c);
      end else begin
        banksel = 1'b0; read = 1'b0;
      end
      @(negedge clk);
      if (c < 4) check("pipe_ready", 64'(ready_a), 64'd1);
      @(posedge clk); #1;
      check("pipe_dvalid_a", 64'(dvalid_a), 64'(c >= 1 && c <= 4));
      check("pipe_dvalid_b", 64'(dvalid_b), 64'(c >= 2 && c <= 5));
      if (c >= 1 && c <= 4) check("pipe_data_a", dataout_a, v[c-1]);
      if (c >= 2 && c <= 5) check("pipe_data_b", dataout_b, v[c-2]);
    end

    // Reset one cycle after a read accept discards it; the array survives.
    access(1'b1, 1'b0, 10'd9, '0, '0, w);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("mrst_dataout_b", dataout_b, 64'd0);
    check("mrst_dataout_a", dataout_a, 64'd0);
    check("mrst_ready", 64'(ready_a), 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mrst_no_dvalid", 64'({dvalid_a, dvalid_b}), 64'd0);
      check("mrst_hold_b", dataout_b, 64'd0);
    end
    read_check("mrst_keep", 10'd9, 64'h01234567_89ABCDEF, w);

    // Sub-bank 2 left idle for 4 cycles while sub-bank 0 stays busy.
    access(1'b0, 1'b1, 10'h010, 64'h0, 8'h00, w);
    access(1'b0, 1'b1, 10'h205, 64'hBEEFCAFE_12345678, 8'hFF, w);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 1'b1, 10'h010, 64'h0, 8'h00, w);
      check("sleep_bank0_waits", 64'(w), 64'(0));
    end
    read_check("sleep_read", 10'h205, 64'hBEEFCAFE_12345678, w);
    check("sleep_wake_waits", 64'(w), 64'(exp_wake));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
    $fatal(1);
  end

endmodule

// File: doc/srambank_pipe.md
Name: srambank_pipe

Overview:
- Parametrised successor of the single-port 1024x64 SRAM bank.
- Splits the array into NBANK sub-banks and adds per-byte write masking and a configurable read-latency pipeline with a valid strobe.
- Adds read/write collision flagging and optional idle-sleep of sub-banks with a ready handshake.
- Sits between the cache/scratchpad controller and the SRAM macros; one instance per logical bank.

Parameters:
- WORDS, 1024, total words; power of two.
- WIDTH, 64, data width in bits; multiple of 8.
- NBANK, 4, sub-banks; power of two, 1..16.
- RD_LAT, 1, read latency in cycles from accept to dvalid; 1..4.
- IDLE_CYC, 16, idle cycles before a sub-bank sleeps; used only with the optional feature.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ADDRESS  input  log2(WORDS)  word address; top log2(NBANK) bits select the sub-bank.
- wd  input  WIDTH  write data.
- wmask  input  WIDTH/8  byte write enables; bit i covers wd[8i+7:8i].
- banksel  input  1  access enable.
- read  input  1  read request.
- write  input  1  write request.
- ready  output  1  access accepted this cycle.
- dataout  output  WIDTH  registered read data; holds between reads.
- dvalid  output  1  one-cycle pulse when dataout is updated.
- collide  output  1  one-cycle pulse, cycle after read&write accepted together.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values:
  - dataout=0, dvalid=0, collide=0.
  - Read pipeline flushed; all sub-banks ACTIVE with idle counters 0.
  - Array contents are not reset.
- Request: req = banksel & (read|write). Accept = req & ready.
- ready is combinational from the target sub-bank state; it is 1 whenever no request is present.
- Write (accepted, write=1):
  - mem[ADDRESS] byte i <= wd byte i for every wmask[i]=1; other bytes unchanged.
  - wmask=0 is a legal no-op that still counts as an access.
- Read (accepted, read=1, write=0):
  - Array is read at the accept edge. Data is that present before any write at the same edge.
  - Data shifts through RD_LAT-1 further register stages.
  - dataout updates and dvalid=1 exactly RD_LAT cycles after the accept edge.
  - Back-to-back reads are accepted every cycle; the pipeline is fully pipelined with no bubbles.
- Read&write together (accepted): the write is performed and the read is dropped; there is no dvalid for it. collide pulses on the next cycle.
- A write to an address with a read in flight does not alter that read's returned data.
- Sub-bank state machine (SRAMBANK_SLEEP_EN only), states ACTIVE, SLEEP, WAKE:
  - ACTIVE: the idle counter increments each cycle with no access to this sub-bank and clears on access. When it reaches IDLE_CYC-1 with no access, the next state is SLEEP.
  - SLEEP: ready=0 for requests targeting it. A request moves it to WAKE and is not accepted.
  - WAKE: ready=0. Unconditionally ACTIVE next cycle, counter 0.
  - The requester holds ADDRESS/wd/wmask/read/write stable until ready=1, so wake-up costs 2 cycles.
  - Only the addressed sub-bank is affected; others keep their state and counters.
- Reset mid-operation: in-flight reads are discarded (no dvalid). A write on the reset edge is not guaranteed.

Optional Feature:
- Macro: SRAMBANK_SLEEP_EN.
- Defined: the sub-bank ACTIVE/SLEEP/WAKE state machine and idle counters are present, and ready can deassert.
- Undefined: no state machine or counters; ready is tied to 1 and IDLE_CYC is ignored. All other behaviour is identical.

Decomposition:
- Package srambank_pkg:
  - bank_state_t enum (ACTIVE, SLEEP, WAKE).
  - Derived width constants: address width, sub-bank select width, and sub-bank depth WORDS/NBANK.
- Sub-module srambank_subbank: one sub-bank array with byte-masked write, registered read and, under the macro, its sleep FSM and counter. Instantiated NBANK times by generate.
- The top level holds the sub-bank decode, the read-data mux, the RD_LAT pipeline, dvalid and collide.

Test Plan:
- Basic write/read, RD_LAT=2: write 0xDEADBEEF_01234567 to addr 5 with wmask=0xFF, then read 5. dvalid pulses exactly 2 cycles after the read accept, with that value; dataout holds afterwards.
- Byte mask: write 0x1111..11 to addr 9, then write 0xFFFF..FF with wmask=0x0F, then read. Expect 0x11111111_FFFFFFFF.
- Pipelined reads, RD_LAT=3: reads of addrs 0,1,2,3 on consecutive cycles. Expect 4 consecutive dvalid pulses in order, starting 3 cycles after the first accept.
- Collision: read=write=1 on addr 7 with wd=0xA5.. and wmask=0xFF. Expect collide pulse next cycle and no dvalid; a later read of 7 returns 0xA5...
- Sleep (macro on, IDLE_CYC=4): leave sub-bank 2 idle 4 cycles, then read from it. Expect ready=0 for 2 cycles, accept on the 3rd, correct data RD_LAT later; sub-bank 0 accesses stay ready=1 throughout.
- Reset mid-read, RD_LAT=3: assert reset 1 cycle after a read accept. Expect no dvalid, dataout=0, ready=1; the array retains previously written data.
